logic_unit_fifo: RTL and testbench

Parametrised, buffered bitwise logic unit: generalises the fixed 32-bit AND/OR/NOR/INV gate blocks into one WIDTH-bit unit with an opcode-selected operation, a valid/ready input handshake and a FIFO_DEPTH-entry result buffer. Sits between the ALU operand muxes and the writeback path, letting logic results queue while writeback stalls.

---
 rtl/logic_unit_fifo_if.sv | 29 ++
 rtl/logic_unit_fifo.sv | 107 ++++++++++
 tb/tb_logic_unit_fifo.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/logic_unit_fifo_if.sv
// Handshake bundle for logic_unit_fifo: operand/opcode input side and buffered result side.
// The master modport is the producer/consumer pair; the slave modport is the logic unit.
interface logic_unit_fifo_if #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic [CntW-1:0]  count;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, zero, count
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, zero, count
    );
endinterface

// File: rtl/logic_unit_fifo.sv
// Opcode-selected WIDTH-bit bitwise logic unit feeding a FIFO_DEPTH-entry result buffer.
// Optional per-entry zero flag enabled by defining LOGIC_ZERO_FLAG_EN.
module logic_unit_fifo #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    logic_unit_fifo_if.slave bus
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [2:0] {
        OpAnd  = 3'b000,
        OpOr   = 3'b001,
        OpNor  = 3'b010,
        OpInv  = 3'b011,
        OpXor  = 3'b100,
        OpNand = 3'b101,
        OpXnor = 3'b110,
        OpPass = 3'b111
    } op_e;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             full, empty, push, pop;
    logic [WIDTH-1:0] result;

    assign full  = (count_q == CntW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    // Acceptance is decided from registered occupancy only, so a pop never frees a slot early.
    assign push  = bus.in_valid & ~full;
    assign pop   = bus.out_ready & ~empty;

    always_comb begin
        result = '0;
        unique case (op_e'(bus.op))
            OpAnd:  result = bus.a & bus.b;
            OpOr:   result = bus.a | bus.b;
            OpNor:  result = ~(bus.a | bus.b);
            OpInv:  result = ~bus.a;
            OpXor:  result = bus.a ^ bus.b;
            OpNand: result = ~(bus.a & bus.b);
            OpXnor: result = ~(bus.a ^ bus.b);
            OpPass: result = bus.a;
            default: result = '0;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through a nonzero count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= result;
        end
    end

`ifdef LOGIC_ZERO_FLAG_EN
    logic [FIFO_DEPTH-1:0] zflag;

    always_ff @(posedge clk) begin
        if (push) begin
            zflag[wr_ptr_q] <= (result == '0);
        end
    end

    assign bus.zero = ~empty & zflag[rd_ptr_q];
`else
    assign bus.zero = 1'b0;
`endif

    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;
    assign bus.count     = count_q;
    assign bus.y         = empty ? '0 : mem[rd_ptr_q];
endmodule

// File: tb/tb_logic_unit_fifo.sv
// Directed self-checking bench for logic_unit_fifo: 32x4 default instance and an 8x2 instance.
module tb_logic_unit_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

`ifdef LOGIC_ZERO_FLAG_EN
    localparam logic ZE = 1'b1;
`else
    localparam logic ZE = 1'b0;
`endif

    always #5 clk = ~clk;

    logic_unit_fifo_if #(.WIDTH(32), .FIFO_DEPTH(4)) b0 ();
    logic_unit_fifo_if #(.WIDTH(8), .FIFO_DEPTH(2)) b1 ();

    logic_unit_fifo #(.WIDTH(32), .FIFO_DEPTH(4)) u0 (.clk(clk), .rst(rst), .bus(b0));
    logic_unit_fifo #(.WIDTH(8), .FIFO_DEPTH(2)) u1 (.clk(clk), .rst(rst), .bus(b1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        b0.in_valid = 1'b1;
        b0.op       = op;
        b0.a        = a;
        b0.b        = b;
        step();
        b0.in_valid = 1'b0;
    endtask

    logic [2:0]  vop [4];
    logic [31:0] va  [4];
    logic [31:0] vb  [4];
    logic [31:0] vy  [4];
    logic        vz  [4];

    initial begin
        b0.in_valid = 0; b0.op = 0; b0.a = 0; b0.b = 0; b0.out_ready = 0;
        b1.in_valid = 0; b1.op = 0; b1.a = 0; b1.b = 0; b1.out_ready = 0;
        step();
        step();
        check("rst_count", 32'(b0.count), 0);
        check("rst_out_valid", 32'(b0.out_valid), 0);
        check("rst_in_ready", 32'(b0.in_ready), 1);
        check("rst_y", b0.y, 0);
        check("rst_zero", 32'(b0.zero), 0);
        rst = 1'b0;

        // Single NOR push
        push0(3'b010, 32'hFFFF0000, 32'h0000FFFF);
        check("nor_out_valid", 32'(b0.out_valid), 1);
        check("nor_y", b0.y, 32'h0);
        check("nor_zero", 32'(b0.zero), 32'(ZE));
        check("nor_count", 32'(b0.count), 1);
        b0.out_ready = 1'b1;
        step();
        b0.out_ready = 1'b0;
        check("nor_pop_count", 32'(b0.count), 0);
        check("nor_pop_y", b0.y, 0);

        // Fill four, reject fifth, drain in order
        vop[0] = 3'b000; va[0] = 32'hFFFF0000; vb[0] = 32'hFFFF0000; vy[0] = 32'hFFFF0000; vz[0] = 0;
        vop[1] = 3'b001; va[1] = 32'hA5A5A5A5; vb[1] = 32'h5A5A5A5A; vy[1] = 32'hFFFFFFFF; vz[1] = 0;
        vop[2] = 3'b011; va[2] = 32'h00000000; vb[2] = 32'h12345678; vy[2] = 32'hFFFFFFFF; vz[2] = 0;
        vop[3] = 3'b100; va[3] = 32'h0000FFFF; vb[3] = 32'h0000FFFF; vy[3] = 32'h00000000; vz[3] = 1;
        for (int i = 0; i < 4; i++) push0(vop[i], va[i], vb[i]);
        check("full_count", 32'(b0.count), 4);
        check("full_in_ready", 32'(b0.in_ready), 0);
        push0(3'b111, 32'hDEADBEEF, 32'h0);
        check("fifth_ignored_count", 32'(b0.count), 4);
        b0.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_y%0d", i), b0.y, vy[i]);
            check($sformatf("drain_zero%0d", i), 32'(b0.zero), 32'(vz[i] & ZE));
            step();
        end
        b0.out_ready = 1'b0;
        check("drained_count", 32'(b0.count), 0);
        check("drained_valid", 32'(b0.out_valid), 0);

        // Full with simultaneous push and pop: only the pop happens
        for (int i = 1; i <= 4; i++) push0(3'b111, 32'(i), 32'h0);
        b0.in_valid = 1'b1; b0.op = 3'b111; b0.a = 32'h99; b0.out_ready = 1'b1;
        step();
        b0.in_valid = 1'b0; b0.out_ready = 1'b0;
        check("fullpp_count", 32'(b0.count), 3);
        check("fullpp_in_ready", 32'(b0.in_ready), 1);
        b0.out_ready = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            check($sformatf("fullpp_y%0d", i), b0.y, 32'(i));
            step();
        end
        b0.out_ready = 1'b0;
        check("fullpp_empty", 32'(b0.count), 0);

        // Streaming, pointers wrap
        b0.in_valid = 1'b1; b0.op = 3'b111; b0.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            b0.a = 32'h1000 + 32'(i);
            step();
            check($sformatf("stream_count%0d", i), 32'(b0.count), 1);
            check($sformatf("stream_y%0d", i), b0.y, 32'h1000 + 32'(i));
        end
        b0.in_valid = 1'b0;
        step();
        b0.out_ready = 1'b0;
        check("stream_end_count", 32'(b0.count), 0);

        // Asynchronous reset mid-stream
        push0(3'b111, 32'hA, 0);
        push0(3'b111, 32'hB, 0);
        push0(3'b111, 32'hC, 0);
        check("pre_rst_count", 32'(b0.count), 3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", 32'(b0.count), 0);
        check("arst_out_valid", 32'(b0.out_valid), 0);
        check("arst_in_ready", 32'(b0.in_ready), 1);
        check("arst_y", b0.y, 0);
        check("arst_zero", 32'(b0.zero), 0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_valid", 32'(b0.out_valid), 0);
        push0(3'b111, 32'h77, 0);
        check("post_rst_y", b0.y, 32'h77);
        check("post_rst_count", 32'(b0.count), 1);
        b0.out_ready = 1'b1;
        step();
        b0.out_ready = 1'b0;
        check("post_rst_empty", 32'(b0.count), 0);

        // 8-bit, 2-deep instance
        b1.in_valid = 1'b1; b1.op = 3'b101; b1.a = 8'hF0; b1.b = 8'h3C;
        step();
        b1.op = 3'b111; b1.a = 8'h5A; b1.b = 8'hFF;
        step();
        b1.in_valid = 1'b0;
        check("w8_count", 32'(b1.count), 2);
        check("w8_in_ready", 32'(b1.in_ready), 0);
        check("w8_nand_y", 32'(b1.y), 32'hCF);
        check("w8_zero", 32'(b1.zero), 0);
        b1.out_ready = 1'b1;
        step();
        check("w8_pass_y", 32'(b1.y), 32'h5A);
        step();
        b1.out_ready = 1'b0;
        check("w8_empty", 32'(b1.count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
